// File: rtl/br_pkg.sv
// Shared definitions for the register-bank read sequencer: widths, PC address
// and the sequencer state encoding.
package br_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    // The read mux returns the program counter at this address instead of a GPR.
    localparam logic [ADDR_W-1:0] PC_ADDR = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        DONE   = 2'd3
    } estado_t;

endpackage

// File: rtl/arbitro_rr.sv
// Round-robin arbiter: picks one requester starting after the last one granted;
// the pointer moves only when the pick is actually accepted.
module arbitro_rr #(
    parameter int NREQ = 2,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [NREQ-1:0] req_i,
    input  logic            aceita_i,
    output logic            valido_o,
    output logic [ID_W-1:0] id_o,
    output logic [NREQ-1:0] gnt_o
);

    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_d;
    logic [2*NREQ-1:0] req_dup;
    logic [NREQ-1:0]   req_rot;
    logic [ID_W-1:0]   offset;
    logic [ID_W:0]     soma;

    // Rotating a doubled copy puts the highest-priority requester at bit 0.
    assign req_dup = {req_i, req_i};
    assign req_rot = req_dup[ptr_q +: NREQ];

    always_comb begin
        valido_o = |req_i;
        offset   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = ID_W'(k);
            end
        end
        soma = {1'b0, ptr_q} + {1'b0, offset};
        if (soma >= (ID_W + 1)'(NREQ)) begin
            soma = soma - (ID_W + 1)'(NREQ);
        end
        id_o = soma[ID_W-1:0];
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
        assign gnt_o[gi] = aceita_i && valido_o && (id_o == ID_W'(gi));
    end

    always_comb begin
        ptr_d = ptr_q;
        if (aceita_i && valido_o) begin
            ptr_d = (id_o == ID_W'(NREQ - 1)) ? '0 : id_o + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sequenciador_leitura_br.sv
// Shares the register bank's single read port among NREQ requesters, reading one or
// two operands per request. Define SEQ_BR_BYPASS_ESCRITA_EN for same-cycle write forwarding.
module sequenciador_leitura_br #(
    parameter int DATA_W = br_pkg::DATA_W,
    parameter int ADDR_W = br_pkg::ADDR_W,
    parameter int NREQ   = 2,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_dual,
    input  logic [NREQ*ADDR_W-1:0] req_addr_a,
    input  logic [NREQ*ADDR_W-1:0] req_addr_b,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDR_W-1:0]      enderecoBR,
    input  logic [DATA_W-1:0]      dBR,
`ifdef SEQ_BR_BYPASS_ESCRITA_EN
    input  logic                   we,
    input  logic [ADDR_W-1:0]      we_addr,
    input  logic [DATA_W-1:0]      we_data,
`endif
    output logic [DATA_W-1:0]      dado_a,
    output logic [DATA_W-1:0]      dado_b,
    output logic                   valido,
    output logic [ID_W-1:0]        valido_id
);

    import br_pkg::*;

    estado_t           estado_q,    estado_d;
    logic [ADDR_W-1:0] addr_a_q,    addr_a_d;
    logic [ADDR_W-1:0] addr_b_q,    addr_b_d;
    logic              dual_q,      dual_d;
    logic [ID_W-1:0]   id_q,        id_d;
    logic [NREQ-1:0]   gnt_q,       gnt_d;
    logic [DATA_W-1:0] dado_a_q,    dado_a_d;
    logic [DATA_W-1:0] dado_b_q,    dado_b_d;
    logic              valido_q,    valido_d;
    logic [ID_W-1:0]   valido_id_q, valido_id_d;

    logic              pode_aceitar;
    logic              arb_valido;
    logic [ID_W-1:0]   arb_id;
    logic [NREQ-1:0]   arb_gnt;
    logic [DATA_W-1:0] dado_lido;
    logic [ADDR_W-1:0] addr_a_vec [NREQ];
    logic [ADDR_W-1:0] addr_b_vec [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
        assign addr_a_vec[gi] = req_addr_a[gi*ADDR_W +: ADDR_W];
        assign addr_b_vec[gi] = req_addr_b[gi*ADDR_W +: ADDR_W];
    end

    // DONE accepts like IDLE so back-to-back requests see no bubble.
    assign pode_aceitar = (estado_q == IDLE) || (estado_q == DONE);

    arbitro_rr #(
        .NREQ (NREQ)
    ) u_arbitro (
        .clock    (clock),
        .resetn   (resetn),
        .req_i    (req),
        .aceita_i (pode_aceitar),
        .valido_o (arb_valido),
        .id_o     (arb_id),
        .gnt_o    (arb_gnt)
    );

    always_comb begin
        enderecoBR = '0;
        case (estado_q)
            READ_A:  enderecoBR = addr_a_q;
            READ_B:  enderecoBR = addr_b_q;
            default: enderecoBR = '0;
        endcase
    end

`ifdef SEQ_BR_BYPASS_ESCRITA_EN
    // A write landing on the register being read this cycle wins over the stale bank value.
    assign dado_lido = (we && (we_addr == enderecoBR)) ? we_data : dBR;
`else
    assign dado_lido = dBR;
`endif

    always_comb begin
        estado_d    = estado_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        dual_d      = dual_q;
        id_d        = id_q;
        gnt_d       = '0;
        dado_a_d    = dado_a_q;
        dado_b_d    = dado_b_q;
        valido_d    = 1'b0;
        valido_id_d = valido_id_q;
        case (estado_q)
            IDLE, DONE: begin
                if (arb_valido) begin
                    addr_a_d = addr_a_vec[arb_id];
                    addr_b_d = addr_b_vec[arb_id];
                    dual_d   = req_dual[arb_id];
                    id_d     = arb_id;
                    gnt_d    = arb_gnt;
                    estado_d = READ_A;
                end else begin
                    estado_d = IDLE;
                end
            end
            READ_A: begin
                dado_a_d = dado_lido;
                if (dual_q) begin
                    estado_d = READ_B;
                end else begin
                    dado_b_d    = '0;
                    valido_d    = 1'b1;
                    valido_id_d = id_q;
                    estado_d    = DONE;
                end
            end
            READ_B: begin
                dado_b_d    = dado_lido;
                valido_d    = 1'b1;
                valido_id_d = id_q;
                estado_d    = DONE;
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            estado_q    <= IDLE;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            dual_q      <= 1'b0;
            id_q        <= '0;
            gnt_q       <= '0;
            dado_a_q    <= '0;
            dado_b_q    <= '0;
            valido_q    <= 1'b0;
            valido_id_q <= '0;
        end else begin
            estado_q    <= estado_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            dual_q      <= dual_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            dado_a_q    <= dado_a_d;
            dado_b_q    <= dado_b_d;
            valido_q    <= valido_d;
            valido_id_q <= valido_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign dado_a    = dado_a_q;
    assign dado_b    = dado_b_q;
    assign valido    = valido_q;
    assign valido_id = valido_id_q;

endmodule

// File: doc/sequenciador_leitura_br.md
Name: sequenciador_leitura_br

Overview:
- Arbitrates the register bank's single read port (3-bit address out, 16-bit data in, combinational mux of reg0..reg6 plus PC at address 7) between NREQ requesters.
- Sequences one- or two-operand reads over that port and returns the captured operands with a one-cycle valid pulse.
- Sits between the fetch/decode control units and the register-bank read multiplexer.

Parameters:
DATA_W, 16, register/data width
ADDR_W, 3, register address width (8 entries, entry 7 = PC)
NREQ, 2, number of requesters

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request; held until the matching gnt bit
req_dual  in  NREQ  1 = read both addr_a and addr_b; 0 = read addr_a only
req_addr_a  in  NREQ*ADDR_W  first operand address; requester i uses slice i
req_addr_b  in  NREQ*ADDR_W  second operand address; requester i uses slice i
gnt  out  NREQ  one-hot acceptance pulse, one cycle
enderecoBR  out  ADDR_W  address driven to the register-bank read mux
dBR  in  DATA_W  read data from the register-bank mux, combinational from enderecoBR
dado_a  out  DATA_W  captured first operand
dado_b  out  DATA_W  captured second operand; 0 for single reads
valido  out  1  one-cycle pulse: dado_a/dado_b valid
valido_id  out  $clog2(NREQ)  index of the requester that owns the current result

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on resetn.
- Reset values: state=IDLE; gnt=0; enderecoBR=0; dado_a=0; dado_b=0; valido=0; valido_id=0; round-robin pointer gives requester 0 highest priority.
- States:
  - IDLE, READ_A, READ_B, DONE. All outputs are registered except enderecoBR, which is decoded from state and the latched addresses.
- Acceptance (in IDLE or DONE, when any req is high):
  - Round-robin pick, starting at the index after the last granted requester.
  - Latch addr_a, addr_b, dual flag and id.
  - gnt[id]<=1; next state READ_A.
  - With no request, next state is IDLE.
- READ_A:
  - enderecoBR=latched addr_a.
  - At the clock edge: dado_a<=dBR. If dual, next state READ_B; otherwise dado_b<=0 and next state DONE.
- READ_B:
  - enderecoBR=latched addr_b.
  - At the clock edge: dado_b<=dBR; next state DONE.
- DONE:
  - valido=1; valido_id=latched id.
  - DONE arbitrates exactly as IDLE, so back-to-back requests lose no cycle.
- Idle address: enderecoBR=0 in IDLE and DONE.
- Latency from the acceptance edge to valido: 2 cycles for a single read, 3 cycles for a dual read.
- Throughput: one request per 2 (single) or 3 (dual) cycles.
- Handshake rules:
  - Requester holds req and its addresses stable until it sees gnt.
  - Requester drops req in the cycle gnt is high; a req still high after gnt is a new request.
  - req changes after acceptance do not affect the transaction in flight.
- Simultaneous requests: exactly one is granted. The pointer advances only on grant, so with both requesters held high, grants alternate 0,1,0,1.
- Aliased addresses: addr_a==addr_b is legal; both captures read the same register.
- Reset mid-transaction: the transaction is dropped with no valido and no gnt; all state returns to reset values.
- dado_a and dado_b hold their value until the next capture.

Optional Feature:
- Macro: SEQ_BR_BYPASS_ESCRITA_EN.
- Defined:
  - Adds ports we (in, 1), we_addr (in, ADDR_W) and we_data (in, DATA_W).
  - In READ_A/READ_B, if we && we_addr==current enderecoBR, capture we_data instead of dBR (write-to-read forwarding, same cycle).
- Undefined: the ports are absent and captures always take dBR.

Decomposition:
- Shared package br_pkg holds:
  - DATA_W and ADDR_W;
  - the address constant for PC (7);
  - the state enum (IDLE, READ_A, READ_B, DONE).
- Sub-module arbitro_rr (NREQ round-robin, one-hot grant with pointer update on accept); the FSM and capture registers stay in the top.

Test Plan:
- Reset check: resetn low mid-READ_B -> all outputs 0 immediately; after release, no valido appears.
- Single read: bank reg3=0x1234; req0 with dual=0, addr_a=3 -> gnt[0] one cycle later; enderecoBR=3 for one cycle; valido 2 cycles after acceptance; dado_a=0x1234, dado_b=0, valido_id=0.
- Dual read with PC: reg5=0x00AA, pc=0x0040; req1 with dual=1, a=5, b=7 -> enderecoBR sequence 5,7; valido at +3; dado_a=0x00AA, dado_b=0x0040, valido_id=1.
- Contention: req0 and req1 held high with single reads -> grants 0,1,0,1; valido on every 2nd cycle with no idle gap (acceptance from DONE).
- Bypass (macro defined): dual read a=2, b=2 with we=1, we_addr=2, we_data=0xBEEF only during READ_B; reg2=0x0001 -> dado_a=0x0001, dado_b=0xBEEF.
